// File: rtl/wb_pkg.sv
// Shared types and load-extension helper for the writeback stage.
// Load funct3 codes, FIFO entry layout and the pure load_extend function.
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  // Halfword loads ignore lo[0]; unknown codes behave like LW.
  function automatic logic [WB_XLEN-1:0] load_extend(
    input logic [WB_XLEN-1:0] data,
    input logic [2:0]         funct3,
    input logic [1:0]         lo
  );
    logic signed [7:0]  sel_b;
    logic signed [15:0] sel_h;
    logic [WB_XLEN-1:0] res;
    sel_b = data[8*lo +: 8];
    sel_h = data[16*lo[1] +: 16];
    case (funct3)
      F3_LB:   res = {{(WB_XLEN-8){sel_b[7]}}, sel_b};
      F3_LBU:  res = {{(WB_XLEN-8){1'b0}}, sel_b};
      F3_LH:   res = {{(WB_XLEN-16){sel_h[15]}}, sel_h};
      F3_LHU:  res = {{(WB_XLEN-16){1'b0}}, sel_h};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bus bundle between execute/memory and the writeback stage.
// Forwarding signals exist only when WRITEBACK_FWD_EN is defined.
interface writeback_stage_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic [2:0]      mem_funct3;
  logic [1:0]      mem_addr_lo;
  logic [4:0]      REG_write_address;
  logic            REG_write_enable;
  logic [XLEN-1:0] REG_write_value;
  logic            wb_busy;
`ifdef WRITEBACK_FWD_EN
  logic [4:0]      fwd_rs1;
  logic [4:0]      fwd_rs2;
  logic            fwd_rs1_hit;
  logic            fwd_rs2_hit;
  logic [XLEN-1:0] fwd_rs1_data;
  logic [XLEN-1:0] fwd_rs2_data;

  modport master (
    output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
    output fwd_rs1, fwd_rs2,
    input  mem_ready, REG_write_address, REG_write_enable, REG_write_value, wb_busy,
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
    input  fwd_rs1, fwd_rs2,
    output mem_ready, REG_write_address, REG_write_enable, REG_write_value, wb_busy,
    output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
    input  mem_ready, REG_write_address, REG_write_enable, REG_write_value, wb_busy
  );
  modport slave (
    input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, mem_funct3, mem_addr_lo,
    output mem_ready, REG_write_address, REG_write_enable, REG_write_value, wb_busy
  );
`endif
endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of wb_entry_t holding extended load results.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  wb_entry_t                i_din,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_din;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates ALU results over buffered load results onto the register-file write port.
// Optional same-cycle forwarding of the write port is enabled by WRITEBACK_FWD_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = WB_XLEN
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  writeback_stage_if.slave   wb
);
  wb_entry_t              w_push_entry;
  wb_entry_t              w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_alu_wr;

  logic                   r_we;
  logic [4:0]             r_addr;
  logic [XLEN-1:0]        r_val;

  // Beats to x0 are accepted but never stored.
  assign w_accept          = wb.mem_valid && !w_full;
  assign w_push            = w_accept && (wb.mem_rd != 5'd0);
  assign w_push_entry.rd   = wb.mem_rd;
  assign w_push_entry.data = load_extend(wb.mem_data, wb.mem_funct3, wb.mem_addr_lo);

  assign w_alu_wr = wb.alu_valid && (wb.alu_rd != 5'd0);
  assign w_pop    = !w_alu_wr && !w_empty;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (SYS_clk),
    .rst     (SYS_reset),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---- output register stage ----
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_val  <= '0;
    end else if (w_alu_wr) begin
      r_we   <= 1'b1;
      r_addr <= wb.alu_rd;
      r_val  <= wb.alu_result;
    end else if (w_pop) begin
      r_we   <= 1'b1;
      r_addr <= w_head.rd;
      r_val  <= w_head.data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign wb.mem_ready         = !w_full;
  assign wb.wb_busy           = (w_count != '0);
  assign wb.REG_write_enable  = r_we;
  assign wb.REG_write_address = r_addr;
  assign wb.REG_write_value   = r_val;

`ifdef WRITEBACK_FWD_EN
  assign wb.fwd_rs1_hit  = r_we && (r_addr == wb.fwd_rs1) && (wb.fwd_rs1 != 5'd0);
  assign wb.fwd_rs2_hit  = r_we && (r_addr == wb.fwd_rs2) && (wb.fwd_rs2 != 5'd0);
  assign wb.fwd_rs1_data = r_val;
  assign wb.fwd_rs2_data = r_val;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random traffic against a queue-based model.
// Forwarding checks are compiled in when WRITEBACK_FWD_EN is defined.
module tb_writeback_stage;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ref_entry_t;

  logic SYS_clk = 1'b0;
  logic SYS_reset;
  writeback_stage_if #(.XLEN(XLEN)) bif ();

  writeback_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .wb        (bif)
  );

  always #5 SYS_clk = ~SYS_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  ref_entry_t  q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_val;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference extension from the load rules, using shifts and masks.
  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f, input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(lo))) & 32'hFF;
    h = (d >> (16 * (int'(lo) / 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic set_idle();
    bif.alu_valid   = 1'b0;
    bif.alu_rd      = 5'd0;
    bif.alu_result  = 32'd0;
    bif.mem_valid   = 1'b0;
    bif.mem_rd      = 5'd0;
    bif.mem_data    = 32'd0;
    bif.mem_funct3  = 3'd2;
    bif.mem_addr_lo = 2'd0;
  endtask

  // One clock: check pre-edge status, advance the model, check the registered outputs after the edge.
  task automatic cycle();
    logic       acc;
    ref_entry_t e;
    chk("mem_ready", {31'd0, bif.mem_ready}, {31'd0, q.size() != DEPTH});
    chk("wb_busy",   {31'd0, bif.wb_busy},   {31'd0, q.size() != 0});
    acc = bif.mem_valid && (q.size() != DEPTH);
    if (bif.alu_valid && bif.alu_rd != 5'd0) begin
      exp_we = 1'b1; exp_addr = bif.alu_rd; exp_val = bif.alu_result;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_addr = e.rd; exp_val = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (acc && bif.mem_rd != 5'd0) begin
      e.rd = bif.mem_rd;
      e.data = ref_ext(bif.mem_data, bif.mem_funct3, bif.mem_addr_lo);
      q.push_back(e);
    end
    last_acc = acc;
    @(posedge SYS_clk);
    #1;
    chk("we",   {31'd0, bif.REG_write_enable},  {31'd0, exp_we});
    chk("addr", {27'd0, bif.REG_write_address}, {27'd0, exp_addr});
    chk("val",  bif.REG_write_value, exp_val);
  endtask

  task automatic offer_load(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f, input logic [1:0] lo);
    bif.mem_valid = 1'b1; bif.mem_rd = rd; bif.mem_data = d;
    bif.mem_funct3 = f; bif.mem_addr_lo = lo;
  endtask

  logic [2:0]  ext_f  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ext_lo [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ext_v  [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    int sent;
    SYS_reset = 1'b1;
    set_idle();
`ifdef WRITEBACK_FWD_EN
    bif.fwd_rs1 = 5'd0;
    bif.fwd_rs2 = 5'd0;
`endif
    exp_we = 1'b0; exp_addr = 5'd0; exp_val = 32'd0; last_acc = 1'b0;
    #1;
    chk("rst_we",    {31'd0, bif.REG_write_enable},  32'd0);
    chk("rst_addr",  {27'd0, bif.REG_write_address}, 32'd0);
    chk("rst_val",   bif.REG_write_value,            32'd0);
    chk("rst_ready", {31'd0, bif.mem_ready},         32'd1);
    chk("rst_busy",  {31'd0, bif.wb_busy},           32'd0);
    @(posedge SYS_clk); @(posedge SYS_clk); #1;
    SYS_reset = 1'b0;

    // ALU only
    bif.alu_valid = 1'b1; bif.alu_rd = 5'd5; bif.alu_result = 32'h1234;
    cycle();
    chk("alu_we",   {31'd0, bif.REG_write_enable},  32'd1);
    chk("alu_addr", {27'd0, bif.REG_write_address}, 32'd5);
    chk("alu_val",  bif.REG_write_value,            32'h1234);
    set_idle();
    cycle();
    chk("alu_we_off", {31'd0, bif.REG_write_enable}, 32'd0);

    // Load extension table
    for (int i = 0; i < 5; i++) begin
      offer_load(5'(i + 1), 32'h80FF_7F01, ext_f[i], ext_lo[i]);
      cycle();
      set_idle();
      cycle();
      chk("ext_we",  {31'd0, bif.REG_write_enable}, 32'd1);
      chk("ext_val", bif.REG_write_value, ext_v[i]);
    end

    // ALU priority with load backpressure
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      bif.alu_valid = 1'b1; bif.alu_rd = 5'(i + 1); bif.alu_result = $urandom;
      if (sent < 3) offer_load(5'(10 + sent), $urandom, 3'd2, 2'd0);
      else bif.mem_valid = 1'b0;
      cycle();
      if (last_acc) sent++;
    end
    chk("prio_sent",  sent, 2);
    chk("prio_ready", {31'd0, bif.mem_ready}, 32'd0);
    bif.alu_valid = 1'b0;
    for (int i = 0; i < 8 && sent < 3; i++) begin
      offer_load(5'(10 + sent), $urandom, 3'd2, 2'd0);
      cycle();
      if (last_acc) sent++;
    end
    chk("prio_third", sent, 3);
    set_idle();
    for (int i = 0; i < 4; i++) cycle();

    // rd=0 handling
    bif.alu_valid = 1'b1; bif.alu_rd = 5'd3; bif.alu_result = 32'h33;
    offer_load(5'd9, 32'hCAFE_F00D, 3'd2, 2'd0);
    cycle();
    bif.mem_valid = 1'b0;
    bif.alu_rd = 5'd0; bif.alu_result = 32'hDEAD;
    cycle();
    chk("rd0_alu_addr", {27'd0, bif.REG_write_address}, 32'd9);
    chk("rd0_alu_val",  bif.REG_write_value, 32'hCAFE_F00D);
    set_idle();
    offer_load(5'd0, 32'h1111_2222, 3'd2, 2'd0);
    cycle();
    chk("rd0_mem_acc",  {31'd0, last_acc}, 32'd1);
    chk("rd0_mem_we",   {31'd0, bif.REG_write_enable}, 32'd0);
    chk("rd0_mem_busy", {31'd0, bif.wb_busy}, 32'd0);
    set_idle();
    cycle();

    // Reset mid-operation with two entries queued
    bif.alu_valid = 1'b1; bif.alu_rd = 5'd4; bif.alu_result = 32'h44;
    for (int i = 0; i < 2; i++) begin
      offer_load(5'(20 + i), $urandom, 3'd2, 2'd0);
      cycle();
    end
    chk("pre_rst_busy", {31'd0, bif.wb_busy}, 32'd1);
    set_idle();
    #2;
    SYS_reset = 1'b1;
    #1;
    q.delete();
    exp_we = 1'b0; exp_addr = 5'd0; exp_val = 32'd0;
    chk("arst_we",    {31'd0, bif.REG_write_enable},  32'd0);
    chk("arst_addr",  {27'd0, bif.REG_write_address}, 32'd0);
    chk("arst_val",   bif.REG_write_value,            32'd0);
    chk("arst_ready", {31'd0, bif.mem_ready},         32'd1);
    chk("arst_busy",  {31'd0, bif.wb_busy},           32'd0);
    @(posedge SYS_clk); #1;
    SYS_reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

`ifdef WRITEBACK_FWD_EN
    bif.alu_valid = 1'b1; bif.alu_rd = 5'd7; bif.alu_result = 32'hABCD;
    cycle();
    set_idle();
    bif.fwd_rs1 = 5'd7; bif.fwd_rs2 = 5'd0;
    #1;
    chk("fwd_rs1_hit",  {31'd0, bif.fwd_rs1_hit}, 32'd1);
    chk("fwd_rs1_data", bif.fwd_rs1_data, 32'hABCD);
    chk("fwd_rs2_hit",  {31'd0, bif.fwd_rs2_hit}, 32'd0);
    bif.fwd_rs1 = 5'd0;
    cycle();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bif.alu_valid   = ($urandom % 10) < 4;
      bif.alu_rd      = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      bif.alu_result  = $urandom;
      bif.mem_valid   = ($urandom % 2) == 1;
      bif.mem_rd      = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      bif.mem_data    = $urandom;
      bif.mem_funct3  = 3'($urandom);
      bif.mem_addr_lo = 2'($urandom);
      cycle();
    end
    set_idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
